xy_input_arbiter: RTL and testbench

XY_INPUT_ARBITER -- requirements
Module: xy_input_arbiter

---
 rtl/xy_input_arbiter.sv | 99 +++++++++
 tb/tb_xy_input_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/xy_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xy_input_arbiter
// Brief    : Round-robin arbiter feeding one registered packet slot to an XY
//            router from the neighbour inputs plus the local resource.
// Revision : 1.0
// ============================================================================
module xy_input_arbiter #(
  parameter int NEIGHBOURS_N = 4,
  parameter int PACKET_W     = 16,
  parameter int ID_W         = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NEIGHBOURS_N:0]                 req_vld_i,
  input  logic [(NEIGHBOURS_N+1)*PACKET_W-1:0]  req_pckt_i,
  output logic [NEIGHBOURS_N:0]                 req_rd_o,
  output logic                                  pckt_vld_o,
  output logic [PACKET_W-1:0]                   pckt_o,
  input  logic                                  pckt_rd_i,
  output logic [ID_W-1:0]                       grant_id_o,
  output logic                                  busy_o
);

  localparam int                REQ_N   = NEIGHBOURS_N + 1;
  localparam logic [ID_W:0]     C_REQ_N = (ID_W+1)'(REQ_N);
  localparam logic [ID_W-1:0]   C_LAST  = ID_W'(NEIGHBOURS_N);
  localparam logic [REQ_N-1:0]  C_ONE   = REQ_N'(1);

  logic                 r_pckt_vld;
  logic [PACKET_W-1:0]  r_pckt;
  logic [ID_W-1:0]      r_grant_id;
  logic [ID_W-1:0]      r_rr_ptr;

  logic                 w_load_en;
  logic                 w_any;
  logic                 w_grant_en;
  logic [ID_W-1:0]      w_grant;
  logic [ID_W:0]        w_sum;
  logic [PACKET_W-1:0]  w_sel_pckt;

  assign w_load_en = !r_pckt_vld || pckt_rd_i;

  // Scan offsets from the far end down so the nearest valid requester to
  // rr_ptr is the last one written and therefore wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int i = REQ_N - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_sum >= C_REQ_N) begin
        w_sum = w_sum - C_REQ_N;
      end
      if (req_vld_i[w_sum[ID_W-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_pckt = '0;
    for (int k = 0; k < REQ_N; k++) begin
      if (w_grant == ID_W'(k)) begin
        w_sel_pckt = req_pckt_i[k*PACKET_W +: PACKET_W];
      end
    end
  end

  // Gated by rst_ni so no source pops a packet while the arbiter is in reset.
  assign w_grant_en = w_load_en && w_any && rst_ni;
  assign req_rd_o   = w_grant_en ? (C_ONE << w_grant) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pckt_vld <= 1'b0;
      r_pckt     <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_pckt_vld <= 1'b1;
        r_pckt     <= w_sel_pckt;
        r_grant_id <= w_grant;
        r_rr_ptr   <= (w_grant == C_LAST) ? '0 : w_grant + ID_W'(1);
      end else begin
        r_pckt_vld <= 1'b0;
      end
    end
  end

  assign pckt_vld_o = r_pckt_vld;
  assign pckt_o     = r_pckt;
  assign grant_id_o = r_grant_id;
  assign busy_o     = r_pckt_vld || (|req_vld_i);

endmodule
`default_nettype wire

// File: tb/tb_xy_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xy_input_arbiter
// Brief    : Directed vector bench for xy_input_arbiter.
// Revision : 1.0
// ============================================================================
module tb_xy_input_arbiter;

  typedef struct {
    logic [4:0]  req;
    logic        rd;
    logic [4:0]  exp_rd;
    logic        exp_busy;
    logic        exp_vld;
    logic [15:0] exp_pckt;
    logic [2:0]  exp_gid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  req_vld = '0;
  logic [79:0] req_pckt;
  logic [4:0]  req_rd;
  logic        pckt_vld;
  logic [15:0] pckt;
  logic        pckt_rd = 1'b0;
  logic [2:0]  grant_id;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Fixed per-source packets; source 2 carries 0x12AB.
  assign req_pckt = {16'h4433, 16'h3322, 16'h12AB, 16'h1111, 16'h0100};

  always #5 clk = ~clk;

  xy_input_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_vld_i  (req_vld),
    .req_pckt_i (req_pckt),
    .req_rd_o   (req_rd),
    .pckt_vld_o (pckt_vld),
    .pckt_o     (pckt),
    .pckt_rd_i  (pckt_rd),
    .grant_id_o (grant_id),
    .busy_o     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] req, input logic rd, input logic [4:0] erd,
                              input logic ebusy, input logic evld, input logic [15:0] ep,
                              input logic [2:0] eg);
    vec_t v;
    v.req = req; v.rd = rd; v.exp_rd = erd; v.exp_busy = ebusy;
    v.exp_vld = evld; v.exp_pckt = ep; v.exp_gid = eg;
    return v;
  endfunction

  vec_t vq[$];
  logic [2:0]  exp_ord[6];
  logic [15:0] exp_pk[6];

  initial begin
    // Sequence starts right after reset (rr_ptr = 0, output slot empty).
    vq.push_back(mk(5'b00100, 1'b0, 5'b00100, 1'b1, 1'b1, 16'h12AB, 3'd2)); // single request
    vq.push_back(mk(5'b00000, 1'b0, 5'b00000, 1'b1, 1'b1, 16'h12AB, 3'd2)); // held
    vq.push_back(mk(5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0, 16'h12AB, 3'd2)); // drained, data holds
    vq.push_back(mk(5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 16'h12AB, 3'd2)); // idle, rd ignored
    vq.push_back(mk(5'b11111, 1'b1, 5'b01000, 1'b1, 1'b1, 16'h3322, 3'd3)); // rr_ptr=3
    vq.push_back(mk(5'b11111, 1'b1, 5'b10000, 1'b1, 1'b1, 16'h4433, 3'd4));
    vq.push_back(mk(5'b11111, 1'b1, 5'b00001, 1'b1, 1'b1, 16'h0100, 3'd0)); // wrap
    vq.push_back(mk(5'b11111, 1'b0, 5'b00000, 1'b1, 1'b1, 16'h0100, 3'd0)); // backpressure x3
    vq.push_back(mk(5'b11111, 1'b0, 5'b00000, 1'b1, 1'b1, 16'h0100, 3'd0));
    vq.push_back(mk(5'b11111, 1'b0, 5'b00000, 1'b1, 1'b1, 16'h0100, 3'd0));
    vq.push_back(mk(5'b11111, 1'b1, 5'b00010, 1'b1, 1'b1, 16'h1111, 3'd1)); // previous+1
    vq.push_back(mk(5'b10001, 1'b1, 5'b10000, 1'b1, 1'b1, 16'h4433, 3'd4)); // scan 2,3,4
    vq.push_back(mk(5'b10001, 1'b1, 5'b00001, 1'b1, 1'b1, 16'h0100, 3'd0)); // 4 -> 0
    vq.push_back(mk(5'b10001, 1'b1, 5'b10000, 1'b1, 1'b1, 16'h4433, 3'd4)); // 0 -> 4
    vq.push_back(mk(5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0, 16'h4433, 3'd4));
    vq.push_back(mk(5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 16'h4433, 3'd4));
    vq.push_back(mk(5'b00010, 1'b0, 5'b00010, 1'b1, 1'b1, 16'h1111, 3'd1)); // 1-cycle latency

    exp_ord = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    exp_pk  = '{16'h0100, 16'h1111, 16'h12AB, 16'h3322, 16'h4433, 16'h0100};

    // Reset state, with requests pending that must not be popped.
    req_vld = 5'b11111;
    pckt_rd = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_vld", 32'(pckt_vld), 32'd0);
    chk("rst_pckt", 32'(pckt), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_rd", 32'(req_rd), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    req_vld = 5'b00000;
    pckt_rd = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      req_vld = vq[i].req;
      pckt_rd = vq[i].rd;
      #1;
      chk($sformatf("v%0d_req_rd", i), 32'(req_rd), 32'(vq[i].exp_rd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].exp_busy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i), 32'(pckt_vld), 32'(vq[i].exp_vld));
      chk($sformatf("v%0d_pckt", i), 32'(pckt), 32'(vq[i].exp_pckt));
      chk($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vq[i].exp_gid));
    end

    // Reset while a packet is held: cleared immediately, no pop.
    @(negedge clk);
    req_vld = 5'b11111;
    pckt_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(pckt_vld), 32'd0);
    chk("mid_rst_pckt", 32'(pckt), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    chk("mid_rst_rd", 32'(req_rd), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_rd_edge", 32'(req_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_vld = 5'b11000;
    pckt_rd = 1'b1;
    #1;
    chk("post_rst_rd", 32'(req_rd), 32'(5'b01000));
    @(posedge clk); #1;
    chk("post_rst_vld", 32'(pckt_vld), 32'd1);
    chk("post_rst_gid", 32'(grant_id), 32'd3);
    chk("post_rst_pckt", 32'(pckt), 32'h3322);

    // Fresh reset, then all five requesting with a free-running reader.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_vld = 5'b11111;
    pckt_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_req_rd", i), 32'(req_rd), 32'(5'b00001 << exp_ord[i]));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_vld", i), 32'(pckt_vld), 32'd1);
      chk($sformatf("rr%0d_gid", i), 32'(grant_id), 32'(exp_ord[i]));
      chk($sformatf("rr%0d_pckt", i), 32'(pckt), 32'(exp_pk[i]));
      @(negedge clk);
    end

    // Idle drain.
    req_vld = 5'b00000;
    pckt_rd = 1'b1;
    @(posedge clk); #1;
    chk("idle_vld", 32'(pckt_vld), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rd", 32'(req_rd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
